// File: rtl/dcache_databank_flush.sv
// Banked D-cache data store with per-word dirty bits and a flush sequencer that streams dirty words out.
// CPU ack one cycle after acceptance; flush beats held on flush_valid until flush_ready, and CPU/fill stall while flushing.
module dcache_databank_flush #(
  parameter int DATABITS     = 32,
  parameter int ADDRBITS     = 5,
  parameter int MEMSIZE      = 2**ADDRBITS,
  parameter int BANKNUM      = 4,
  parameter int BANKDATABITS = DATABITS/BANKNUM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic [DATABITS-1:0] cpu_data_in,
  input  logic [BANKNUM-1:0]  cpu_byteenable,
  output logic                cpu_ack,
  output logic [DATABITS-1:0] cpu_data_out,
  input  logic                fill_we,
  input  logic [ADDRBITS-1:0] fill_addr,
  input  logic [DATABITS-1:0] fill_data,
  input  logic                flush_start,
  output logic                flush_busy,
  output logic                flush_done,
  output logic                flush_valid,
  input  logic                flush_ready,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic [DATABITS-1:0] flush_data,
  output logic [ADDRBITS:0]   dirty_count
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_READ, S_OUT, S_DONE} state_t;

  typedef struct packed {
    logic [ADDRBITS-1:0] addr;
    logic [DATABITS-1:0] data;
  } flush_beat_t;

  localparam logic [ADDRBITS-1:0] LAST_ADDR = ADDRBITS'(MEMSIZE-1);
  localparam logic [ADDRBITS-1:0] PTR_ONE   = ADDRBITS'(1);
  localparam logic [ADDRBITS:0]   CNT_ONE   = (ADDRBITS+1)'(1);

  state_t              state;
  logic [ADDRBITS-1:0] ptr;
  flush_beat_t         beat;
  logic [MEMSIZE-1:0]  dirty;
  logic [DATABITS-1:0] mem [MEMSIZE];

  logic cpu_acc;
  logic fill_acc;
  logic cpu_wr;
  logic cpu_dirtying;
  logic ptr_last;

  // The flush engine owns the RAM port for its whole run, so fill and CPU simply lose arbitration.
  assign fill_acc     = fill_we & ~flush_busy;
  assign cpu_acc      = cpu_req & ~fill_we & ~flush_busy;
  assign cpu_wr       = cpu_acc & cpu_we;
  assign cpu_dirtying = cpu_wr & (|cpu_byteenable);
  assign ptr_last     = (ptr == LAST_ADDR);

  assign flush_addr = beat.addr;
  assign flush_data = beat.data;

  always_ff @(posedge clk) begin
    if (fill_acc) begin
      mem[fill_addr] <= fill_data;
    end else if (cpu_wr) begin
      for (int b = 0; b < BANKNUM; b++) begin
        if (cpu_byteenable[b])
          mem[cpu_addr][b*BANKDATABITS +: BANKDATABITS] <= cpu_data_in[b*BANKDATABITS +: BANKDATABITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      beat         <= '0;
      dirty        <= '0;
      dirty_count  <= '0;
      cpu_ack      <= 1'b0;
      cpu_data_out <= '0;
      flush_busy   <= 1'b0;
      flush_done   <= 1'b0;
      flush_valid  <= 1'b0;
    end else begin
      cpu_ack    <= cpu_acc;
      flush_done <= 1'b0;
      // Read-before-write: a CPU write returns the word as it was before the update.
      if (cpu_acc)
        cpu_data_out <= mem[cpu_addr];

      // Fill, CPU write and flush handshake are mutually exclusive, so at most one count step per cycle.
      if (fill_acc) begin
        dirty[fill_addr] <= 1'b0;
        if (dirty[fill_addr])
          dirty_count <= dirty_count - CNT_ONE;
      end else if (cpu_dirtying) begin
        dirty[cpu_addr] <= 1'b1;
        if (!dirty[cpu_addr])
          dirty_count <= dirty_count + CNT_ONE;
      end

      case (state)
        S_IDLE: begin
          if (flush_start) begin
            state      <= S_SCAN;
            ptr        <= '0;
            flush_busy <= 1'b1;
          end
        end
        S_SCAN: begin
          if (dirty[ptr]) begin
            state <= S_READ;
          end else if (ptr_last) begin
            state      <= S_DONE;
            flush_done <= 1'b1;
          end else begin
            ptr <= ptr + PTR_ONE;
          end
        end
        S_READ: begin
          beat.addr   <= ptr;
          beat.data   <= mem[ptr];
          flush_valid <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (flush_ready) begin
            dirty[ptr]  <= 1'b0;
            dirty_count <= dirty_count - CNT_ONE;
            flush_valid <= 1'b0;
            if (ptr_last) begin
              state      <= S_DONE;
              flush_done <= 1'b1;
            end else begin
              ptr   <= ptr + PTR_ONE;
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          flush_busy <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_databank_flush.sv
// Directed bench for dcache_databank_flush: CPU/fill arbitration, dirty counting, flush streaming and reset abort.
module tb_dcache_databank_flush;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_byteenable;
  logic        cpu_ack;
  logic [31:0] cpu_data_out;
  logic        fill_we;
  logic [4:0]  fill_addr;
  logic [31:0] fill_data;
  logic        flush_start;
  logic        flush_busy;
  logic        flush_done;
  logic        flush_valid;
  logic        flush_ready;
  logic [4:0]  flush_addr;
  logic [31:0] flush_data;
  logic [5:0]  dirty_count;

  int n_cmp;
  int n_err;

  dcache_databank_flush dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_data_in    (cpu_data_in),
    .cpu_byteenable (cpu_byteenable),
    .cpu_ack        (cpu_ack),
    .cpu_data_out   (cpu_data_out),
    .fill_we        (fill_we),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .flush_start    (flush_start),
    .flush_busy     (flush_busy),
    .flush_done     (flush_done),
    .flush_valid    (flush_valid),
    .flush_ready    (flush_ready),
    .flush_addr     (flush_addr),
    .flush_data     (flush_data),
    .dirty_count    (dirty_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle CPU request; returns just after the edge where the ack is visible.
  task automatic cpu_op(input logic we, input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_data_in = data; cpu_byteenable = be;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic pulse_start();
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({cpu_ack, flush_busy, flush_done, flush_valid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {cpu_ack, flush_busy, flush_done, flush_valid});
    end
    n_cmp++;
    if (dirty_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", dirty_count); end
    n_cmp++;
    if ({cpu_data_out, flush_data, flush_addr} !== 69'd0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h want 0", cpu_data_out, flush_data, flush_addr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write_read();
    cpu_op(1'b1, 5'd3, 32'hAABBCCDD, 4'b1111);
    n_cmp++;
    if (cpu_ack !== 1'b1 || dirty_count !== 6'd1) begin
      n_err++; $display("FAIL wr_full: ack=%b count=%0d want ack=1 count=1", cpu_ack, dirty_count);
    end
    cpu_op(1'b1, 5'd3, 32'h00000011, 4'b0001);
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_data_out !== 32'hAABBCCDD || dirty_count !== 6'd1) begin
      n_err++; $display("FAIL wr_byte: ack=%b old=%h count=%0d want 1/aabbccdd/1", cpu_ack, cpu_data_out, dirty_count);
    end
    cpu_op(1'b0, 5'd3, 32'h0, 4'b0000);
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_data_out !== 32'hAABBCC11) begin
      n_err++; $display("FAIL rd_merge: ack=%b data=%h want 1/aabbcc11", cpu_ack, cpu_data_out);
    end
    tick();
    n_cmp++;
    if (cpu_ack !== 1'b0 || cpu_data_out !== 32'hAABBCC11) begin
      n_err++; $display("FAIL ack_drop_hold: ack=%b data=%h want 0/aabbcc11", cpu_ack, cpu_data_out);
    end
    cpu_op(1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000);
    n_cmp++;
    if (cpu_ack !== 1'b1 || dirty_count !== 6'd1) begin
      n_err++; $display("FAIL wr_be0: ack=%b count=%0d want 1/1", cpu_ack, dirty_count);
    end
  endtask

  task automatic test_fill_priority();
    fill_we = 1'b1; fill_addr = 5'd7; fill_data = 32'h12345678;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
    tick();
    fill_we = 1'b0;
    n_cmp++;
    if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL fill_wins: ack=%b want 0", cpu_ack); end
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_data_out !== 32'h12345678) begin
      n_err++; $display("FAIL retry_read: ack=%b data=%h want 1/12345678", cpu_ack, cpu_data_out);
    end
    fill_we = 1'b1; fill_addr = 5'd3; fill_data = 32'hCAFEF00D;
    tick();
    fill_we = 1'b0;
    n_cmp++;
    if (dirty_count !== 6'd0) begin n_err++; $display("FAIL fill_clean: count=%0d want 0", dirty_count); end
  endtask

  task automatic test_flush_basic();
    logic [4:0]  a [2];
    logic [31:0] d [2];
    int beats;
    bit done_seen;
    beats = 0; done_seen = 0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    cpu_op(1'b1, 5'd0, 32'h01020304, 4'b1111);
    cpu_op(1'b1, 5'd31, 32'hDEADBEEF, 4'b1111);
    n_cmp++;
    if (dirty_count !== 6'd2) begin n_err++; $display("FAIL pre_flush_count: got %0d want 2", dirty_count); end
    flush_ready = 1'b1;
    pulse_start();
    n_cmp++;
    if (flush_busy !== 1'b1) begin n_err++; $display("FAIL busy_rise: got %b want 1", flush_busy); end
    for (int k = 0; k < 200 && !done_seen; k++) begin
      if (flush_valid && flush_ready) begin
        if (beats < 2) begin a[beats] = flush_addr; d[beats] = flush_data; end
        beats++;
      end
      if (flush_done) done_seen = 1;
      else tick();
    end
    n_cmp++;
    if (!done_seen) begin n_err++; $display("FAIL flush_timeout: done=0 want 1"); end
    n_cmp++;
    if (beats !== 2) begin n_err++; $display("FAIL beat_count: got %0d want 2", beats); end
    n_cmp++;
    if (a[0] !== 5'd0 || d[0] !== 32'h01020304) begin
      n_err++; $display("FAIL beat0: got %0d/%h want 0/01020304", a[0], d[0]);
    end
    n_cmp++;
    if (a[1] !== 5'd31 || d[1] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL beat1: got %0d/%h want 31/deadbeef", a[1], d[1]);
    end
    n_cmp++;
    if (dirty_count !== 6'd0) begin n_err++; $display("FAIL post_flush_count: got %0d want 0", dirty_count); end
    tick();
    n_cmp++;
    if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b busy=%b want 0/0", flush_done, flush_busy);
    end
  endtask

  task automatic test_flush_backpressure();
    logic [4:0]  a0;
    logic [31:0] d0;
    int ack_bad;
    int beats;
    bit seen;
    bit done_seen;
    ack_bad = 0; beats = 0; seen = 0; done_seen = 0;
    cpu_op(1'b1, 5'd2, 32'h55AA55AA, 4'b1111);
    flush_ready = 1'b0;
    pulse_start();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd2;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (cpu_ack !== 1'b0) ack_bad++;
      if (flush_valid) seen = 1;
      else tick();
    end
    a0 = flush_addr; d0 = flush_data;
    n_cmp++;
    if (!seen || a0 !== 5'd2 || d0 !== 32'h55AA55AA) begin
      n_err++; $display("FAIL bp_beat: seen=%b got %0d/%h want 1 2/55aa55aa", seen, a0, d0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ack !== 1'b0) ack_bad++;
      n_cmp++;
      if (flush_valid !== 1'b1 || flush_addr !== a0 || flush_data !== d0) begin
        n_err++; $display("FAIL bp_stable%0d: v=%b %0d/%h want 1 %0d/%h", i, flush_valid, flush_addr, flush_data, a0, d0);
      end
    end
    flush_ready = 1'b1;
    for (int k = 0; k < 100 && !done_seen; k++) begin
      if (flush_busy && cpu_ack !== 1'b0) ack_bad++;
      if (flush_valid && flush_ready) beats++;
      if (flush_done) done_seen = 1;
      else tick();
    end
    n_cmp++;
    if (!done_seen || beats !== 1) begin
      n_err++; $display("FAIL bp_done: done=%b beats=%0d want 1/1", done_seen, beats);
    end
    n_cmp++;
    if (ack_bad !== 0) begin n_err++; $display("FAIL ack_while_busy: got %0d acks want 0", ack_bad); end
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      tick();
      if (cpu_ack) seen = 1;
    end
    cpu_req = 1'b0;
    n_cmp++;
    if (!seen || cpu_data_out !== 32'h55AA55AA || dirty_count !== 6'd0) begin
      n_err++; $display("FAIL post_bp_read: ack=%b data=%h count=%0d want 1/55aa55aa/0", seen, cpu_data_out, dirty_count);
    end
  endtask

  task automatic test_empty_flush();
    int done_k;
    bit valid_seen;
    done_k = -1; valid_seen = 0;
    tick();
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      if (flush_valid) valid_seen = 1;
      if (flush_done && done_k < 0) done_k = k;
      tick();
    end
    n_cmp++;
    if (done_k !== 33) begin n_err++; $display("FAIL empty_latency: done at N+%0d want N+33", done_k); end
    n_cmp++;
    if (valid_seen) begin n_err++; $display("FAIL empty_valid: valid seen=1 want 0"); end
  endtask

  task automatic test_reset_mid_flush();
    bit seen;
    int bad;
    seen = 0; bad = 0;
    cpu_op(1'b1, 5'd4, 32'h44444444, 4'b1111);
    cpu_op(1'b1, 5'd9, 32'h99999999, 4'b0110);
    n_cmp++;
    if (dirty_count !== 6'd2) begin n_err++; $display("FAIL rmf_count: got %0d want 2", dirty_count); end
    flush_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 100 && !seen; k++) begin
      if (flush_valid) seen = 1;
      else tick();
    end
    n_cmp++;
    if (!seen || flush_addr !== 5'd4) begin
      n_err++; $display("FAIL rmf_out: valid=%b addr=%0d want 1/4", seen, flush_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (flush_busy !== 1'b0 || flush_valid !== 1'b0 || dirty_count !== 6'd0 || flush_done !== 1'b0) begin
      n_err++; $display("FAIL rmf_abort: busy=%b valid=%b count=%0d done=%b want 0/0/0/0",
                        flush_busy, flush_valid, dirty_count, flush_done);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (flush_done !== 1'b0 || flush_busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL rmf_quiet: got %0d bad cycles want 0", bad); end
    flush_ready = 1'b1;
    cpu_op(1'b1, 5'd4, 32'h0000AAAA, 4'b0011);
    n_cmp++;
    if (dirty_count !== 6'd1) begin n_err++; $display("FAIL rmf_redirty: got %0d want 1", dirty_count); end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd10; cpu_data_in = 32'h0A0A0A0A; cpu_byteenable = 4'b1111;
    tick();
    n_cmp++;
    if (cpu_ack !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ack: got %b want 1", cpu_ack); end
    cpu_we = 1'b0;
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_data_out !== 32'h0A0A0A0A || dirty_count !== 6'd2) begin
      n_err++; $display("FAIL b2b_rd: ack=%b data=%h count=%0d want 1/0a0a0a0a/2", cpu_ack, cpu_data_out, dirty_count);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data_in = '0; cpu_byteenable = '0;
    fill_we = 1'b0; fill_addr = '0; fill_data = '0; flush_start = 1'b0; flush_ready = 1'b0;
    test_reset();
    test_cpu_write_read();
    test_fill_priority();
    test_flush_basic();
    test_flush_backpressure();
    test_empty_flush();
    test_reset_mid_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
